cordic_pipe: RTL
================

CORDIC_PIPE -- requirements
Module: cordic_pipe

Interface
REQ-001 SHALL have parameter W, default 16, meaning the x/y input width and the z (angle) width, signed two's complement.
REQ-002 SHALL have parameter N, default 12, meaning the number of iteration stages, with legal range 4..W-1.
REQ-003 SHALL have parameter TAGW, default 4, meaning the width of the sideband tag carried alongside each sample.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the input sample is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 SHALL have port in_mode, input, 1 bit: 0 selects rotation mode; 1 selects vectoring mode.
REQ-009 SHALL have ports in_x, in_y and in_z, each input, W bits, signed; in_z is a binary angle where 2^(W-1) LSB = pi.
REQ-010 SHALL have port in_tag, input, TAGW bits: opaque sideband data.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-013 SHALL have ports out_x and out_y, each output, W+2 bits, signed, uncompensated (CORDIC gain K ~ 1.6468 included).
REQ-014 SHALL have port out_z, output, W bits, signed binary angle.
REQ-015 SHALL have ports out_mode (1 bit) and out_tag (TAGW bits), outputs, echoing the inputs of the same sample.

Function
REQ-016 SHALL accept a sample on a cycle where in_valid && in_ready are both 1.
REQ-017 SHALL drive in_ready = !rst && (!out_valid || out_ready), combinationally.
REQ-018 SHALL advance the whole pipeline (all stages, data plus valid bits) only when in_ready = 1; otherwise every stage, including the outputs, holds.
REQ-019 SHALL carry bubbles: a stage valid bit becomes 0 when the preceding stage was not valid at an advance.
REQ-020 SHALL have a latency of exactly N+1 advancing cycles from acceptance to out_valid; with out_ready held at 1, throughput is 1 sample per cycle.
REQ-021 SHALL make stage 0 register the sign-extended input at W+2 bits and apply pre-rotation.
REQ-022 SHALL apply rotation-mode pre-rotation as follows: z top two bits 01 (z >= pi/2) -> (x,y,z) = (-y, x, z-pi/2); top two bits 10 (z < -pi/2) -> (y, -x, z+pi/2); otherwise pass through.
REQ-023 SHALL apply vectoring-mode pre-rotation as follows: x<0 and y>=0 -> (y, -x, z+pi/2); x<0 and y<0 -> (-y, x, z-pi/2); otherwise pass through.
REQ-024 SHALL make stage i (i = 0..N-1) compute d = +1 if (mode=0 and z>=0) or (mode=1 and y<0), else d = -1.
REQ-025 SHALL make stage i then compute x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i, using arithmetic shifts and the un-updated x, y as operands.
REQ-026 SHALL compute atan_i = round(atan(2^-i)/pi * 2^(W-1)) at elaboration from the parameters; no hand-entered table.
REQ-027 SHALL wrap z arithmetic modulo 2^W (angle wrap-around at +/-pi is intended).
REQ-028 SHALL keep x/y at W+2 bits with no saturation; headroom covers K*sqrt(2)*2^(W-1).
REQ-029 SHALL pipeline mode and tag alongside the data with identical latency and stalling.
REQ-030 SHALL hold out_* stable while out_valid=1 and out_ready=0.

Reset
REQ-031 SHALL, on a clock edge with rst=1, clear every stage valid bit and data register and every output (out_valid, out_x, out_y, out_z, out_mode, out_tag) to 0, discarding in-flight samples.
REQ-032 SHALL, in the first cycle after rst deasserts, have in_ready=1 and out_valid=0.

Verification (W=16, N=12; tolerance +/-4 LSB on x/y/z)
REQ-033 SHALL cover rotation mode: in_x=10000, in_y=0, in_z=8192 (pi/4) -> out_x ~ 11645, out_y ~ 11645, out_z ~ 0, out_valid exactly 13 cycles after acceptance.
REQ-034 SHALL cover vectoring mode: in_x=10000, in_y=10000, in_z=0 -> out_x ~ 23290, out_y ~ 0, out_z ~ 8192.
REQ-035 SHALL cover pre-rotation in both modes: rotation with in_x=10000, in_y=0, in_z=-24576 (-3pi/4) -> out_x ~ -11645, out_y ~ -11645; vectoring with in_x=-10000, in_y=10000 -> out_z ~ 24576, out_y ~ 0.
REQ-036 SHALL cover backpressure: stream 20 tagged samples, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid=1, outputs held, all 20 tags emerge in order with no loss or duplication.
REQ-037 SHALL cover reset mid-flight: assert rst for 1 cycle with 6 samples in flight -> all outputs 0 and out_valid=0 the next cycle, no stale sample emerges afterwards.
REQ-038 SHALL cover back-to-back mixed modes and bubbles: alternate in_mode each cycle with in_valid toggling -> each result matches a bit-accurate reference model, and the bubble pattern is preserved at the output.

Source files
------------

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC with rotation/vectoring modes, valid/ready flow control,
// and a sideband tag that travels with each sample. Outputs carry the raw CORDIC gain.
module cordic_pipe #(
    parameter int W    = 16,
    parameter int N    = 12,
    parameter int TAGW = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic signed [W-1:0]    in_x,
    input  logic signed [W-1:0]    in_y,
    input  logic signed [W-1:0]    in_z,
    input  logic [TAGW-1:0]        in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [W+1:0]    out_x,
    output logic signed [W+1:0]    out_y,
    output logic signed [W-1:0]    out_z,
    output logic                   out_mode,
    output logic [TAGW-1:0]        out_tag
);

    localparam int  XW = W + 2;
    localparam real PI = 3.14159265358979323846;
    localparam logic signed [W-1:0] QTR = {2'b01, {(W-2){1'b0}}};

    // Arctangent table in binary-angle units, built from the parameters at elaboration.
    function automatic logic [N*W-1:0] atan_table();
        logic [N*W-1:0] t;
        real            p;
        real            scale;
        real            a;
        t     = '0;
        p     = 1.0;
        scale = 1.0;
        for (int k = 0; k < W - 1; k++) scale = scale * 2.0;
        for (int i = 0; i < N; i++) begin
            a = $atan(p) / PI * scale;
            t[i*W +: W] = W'($rtoi(a + 0.5));
            p = p / 2.0;
        end
        return t;
    endfunction

    localparam logic [N*W-1:0] ATAN_TAB = atan_table();

    logic signed [XW-1:0] x_q [0:N];
    logic signed [XW-1:0] y_q [0:N];
    logic signed [W-1:0]  z_q [0:N];
    logic                 mode_q [0:N];
    logic [TAGW-1:0]      tag_q [0:N];
    logic                 vld_q [0:N];

    logic signed [XW-1:0] x_d [0:N];
    logic signed [XW-1:0] y_d [0:N];
    logic signed [W-1:0]  z_d [0:N];

    assign in_ready = !rst && (!vld_q[N] || out_ready);

    always_comb begin
        logic signed [XW-1:0] ext_x;
        logic signed [XW-1:0] ext_y;
        logic signed [XW-1:0] sx;
        logic signed [XW-1:0] sy;
        logic signed [W-1:0]  at;
        logic                 dpos;
        for (int i = 0; i <= N; i++) begin
            x_d[i] = '0;
            y_d[i] = '0;
            z_d[i] = '0;
        end
        sx    = '0;
        sy    = '0;
        at    = '0;
        dpos  = 1'b0;
        ext_x = {{2{in_x[W-1]}}, in_x};
        ext_y = {{2{in_y[W-1]}}, in_y};

        // Pre-rotation by +/-pi/2 brings the vector into the CORDIC convergence range.
        x_d[0] = ext_x;
        y_d[0] = ext_y;
        z_d[0] = in_z;
        if (!in_mode) begin
            if (in_z[W-1:W-2] == 2'b01) begin
                x_d[0] = -ext_y;
                y_d[0] = ext_x;
                z_d[0] = in_z - QTR;
            end else if (in_z[W-1:W-2] == 2'b10) begin
                x_d[0] = ext_y;
                y_d[0] = -ext_x;
                z_d[0] = in_z + QTR;
            end
        end else if (in_x[W-1]) begin
            if (!in_y[W-1]) begin
                x_d[0] = ext_y;
                y_d[0] = -ext_x;
                z_d[0] = in_z + QTR;
            end else begin
                x_d[0] = -ext_y;
                y_d[0] = ext_x;
                z_d[0] = in_z - QTR;
            end
        end

        for (int i = 0; i < N; i++) begin
            dpos = mode_q[i] ? y_q[i][XW-1] : !z_q[i][W-1];
            sx   = x_q[i] >>> i;
            sy   = y_q[i] >>> i;
            at   = ATAN_TAB[i*W +: W];
            if (dpos) begin
                x_d[i+1] = x_q[i] - sy;
                y_d[i+1] = y_q[i] + sx;
                z_d[i+1] = z_q[i] - at;
            end else begin
                x_d[i+1] = x_q[i] + sy;
                y_d[i+1] = y_q[i] - sx;
                z_d[i+1] = z_q[i] + at;
            end
        end
    end

    // The whole pipe moves in lockstep; a stall freezes every stage including the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= N; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                z_q[i]    <= '0;
                mode_q[i] <= 1'b0;
                tag_q[i]  <= '0;
                vld_q[i]  <= 1'b0;
            end
        end else if (in_ready) begin
            x_q[0]    <= x_d[0];
            y_q[0]    <= y_d[0];
            z_q[0]    <= z_d[0];
            mode_q[0] <= in_mode;
            tag_q[0]  <= in_tag;
            vld_q[0]  <= in_valid;
            for (int i = 1; i <= N; i++) begin
                x_q[i]    <= x_d[i];
                y_q[i]    <= y_d[i];
                z_q[i]    <= z_d[i];
                mode_q[i] <= mode_q[i-1];
                tag_q[i]  <= tag_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[N];
    assign out_x     = x_q[N];
    assign out_y     = y_q[N];
    assign out_z     = z_q[N];
    assign out_mode  = mode_q[N];
    assign out_tag   = tag_q[N];

endmodule
